// File: rtl/sram.sv
//==============================================================================
// Module  : sram
// Brief   : Single-clock 1W/1R SRAM with registered, read-first read port.
//           Optional per-word even parity with error flag (SRAM_PARITY_EN).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] wadr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] radr,
  output logic [DATA_WIDTH-1:0] rdata
`ifdef SRAM_PARITY_EN
  ,
  output logic                  rerr
`endif
);

`ifdef SRAM_PARITY_EN
  localparam int c_word_w = DATA_WIDTH + 1;
`else
  localparam int c_word_w = DATA_WIDTH;
`endif

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);

  logic [c_word_w-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [c_word_w-1:0]   rword;
  logic [c_word_w-1:0]   wword;
  logic                  wr_ok;
  logic                  rd_ok;

  always_comb begin
    wr_ok = wen && ({1'b0, wadr} < c_depth);
    rd_ok = ren && ({1'b0, radr} < c_depth);
`ifdef SRAM_PARITY_EN
    wword = {^wdata, wdata};
`else
    wword = wdata;
`endif
    // Out-of-range reads return an all-zero word, which also has clean parity.
    rword   = rd_ok ? mem_q[radr] : '0;
    rdata_d = ren ? rword[DATA_WIDTH-1:0] : rdata_q;
  end

  // Memory shares the register block so writes are gated by rst on the same edge;
  // mem_q itself is never cleared. Old contents feed rdata_d, giving read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (wr_ok) begin
        mem_q[wadr] <= wword;
      end
    end
  end

  assign rdata = rdata_q;

`ifdef SRAM_PARITY_EN
  logic rerr_q;
  logic rerr_d;

  always_comb begin
    rerr_d = ren ? (^rword) : rerr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rerr_q <= 1'b0;
    end else begin
      rerr_q <= rerr_d;
    end
  end

  assign rerr = rerr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram.sv
//==============================================================================
// Module  : tb_sram
// Brief   : Self-checking bench for sram against an array-based reference model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sram;

  localparam int DW    = 128;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [AW-1:0] wadr;
  logic [DW-1:0] wdata;
  logic          ren;
  logic [AW-1:0] radr;
  logic [DW-1:0] rdata;
`ifdef SRAM_PARITY_EN
  logic          rerr;
`endif

  sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .wadr  (wadr),
    .wdata (wdata),
    .ren   (ren),
    .radr  (radr),
    .rdata (rdata)
`ifdef SRAM_PARITY_EN
    ,
    .rerr  (rerr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] mdl       [1 << AW];
  bit            mdl_valid [1 << AW];
  logic [DW-1:0] exp_rdata;
  bit            exp_known;

  int checks = 0;
  int errors = 0;

  // Advance one edge, applying the read-before-write rules to the model.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (ren) begin
        if (int'(radr) >= DEPTH) begin
          exp_rdata = '0;
          exp_known = 1'b1;
        end else begin
          exp_rdata = mdl[radr];
          exp_known = mdl_valid[radr];
        end
      end
      if (wen && int'(wadr) < DEPTH) begin
        mdl[wadr]       = wdata;
        mdl_valid[wadr] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; wadr = '0; radr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    exp_rdata = '0;
    exp_known = 1'b1;
    #2;
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL reset_async rdata=%0h expected 0", rdata);
    end
`ifdef SRAM_PARITY_EN
    checks++;
    if (rerr !== 1'b0) begin
      errors++; $display("FAIL reset_rerr rerr=%b expected 0", rerr);
    end
`endif
    // Reads and writes held off while in reset
    wen = 1'b1; wadr = 10'd200; wdata = 128'hDEAD; ren = 1'b1; radr = 10'd200;
    step(); step();
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL reset_hold rdata=%0h expected 0", rdata);
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    wen = 1'b1; wadr = 10'd97; wdata = 128'd137;
    step();
    wen = 1'b0; ren = 1'b1; radr = 10'd97;
    step();
    checks++;
    if (rdata !== 128'd137) begin
      errors++; $display("FAIL wr_rd_97 rdata=%0d expected 137", rdata);
    end
    ren = 1'b0; wen = 1'b1; wadr = 10'd83; wdata = 128'd84;
    step();
    wen = 1'b0; ren = 1'b1; radr = 10'd83;
    step();
    checks++;
    if (rdata !== 128'd84) begin
      errors++; $display("FAIL wr_rd_83 rdata=%0d expected 84", rdata);
    end
    ren = 1'b0; wen = 1'b1; wadr = 10'd4; wdata = 128'd39;
    step();
    wen = 1'b0;
    step();
    checks++;
    if (rdata !== 128'd84) begin
      errors++; $display("FAIL hold_over_write rdata=%0d expected 84", rdata);
    end
    ren = 1'b1; radr = 10'd4;
    step();
    checks++;
    if (rdata !== 128'd39) begin
      errors++; $display("FAIL wr_rd_4 rdata=%0d expected 39", rdata);
    end
    ren = 1'b0; radr = 10'd97;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (rdata !== 128'd39) begin
      errors++; $display("FAIL hold_idle rdata=%0d expected 39", rdata);
    end
  endtask

  task automatic test_read_first();
    wen = 1'b1; wadr = 10'd10; wdata = 128'd7;
    step();
    wadr = 10'd10; wdata = 128'd5; ren = 1'b1; radr = 10'd10;
    step();
    checks++;
    if (rdata !== 128'd7) begin
      errors++; $display("FAIL read_first_old rdata=%0d expected 7", rdata);
    end
    wen = 1'b0;
    step();
    checks++;
    if (rdata !== 128'd5) begin
      errors++; $display("FAIL read_first_new rdata=%0d expected 5", rdata);
    end
    ren = 1'b0;
  endtask

  task automatic test_async_reset();
    ren = 1'b1; radr = 10'd4;
    step();
    ren = 1'b0;
    checks++;
    if (rdata !== 128'd39) begin
      errors++; $display("FAIL pre_reset rdata=%0d expected 39", rdata);
    end
    #2;
    rst = 1'b1;
    exp_rdata = '0;
    #1;
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL async_clear rdata=%0h expected 0", rdata);
    end
    // A write on an edge during reset must not touch memory
    wen = 1'b1; wadr = 10'd4; wdata = 128'd999; ren = 1'b1; radr = 10'd4;
    step();
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL reset_read_ignored rdata=%0h expected 0", rdata);
    end
    rst = 1'b0; wen = 1'b0;
    step();
    checks++;
    if (rdata !== 128'd39) begin
      errors++; $display("FAIL retained_after_reset rdata=%0d expected 39", rdata);
    end
    ren = 1'b0;
  endtask

  task automatic test_out_of_range();
    ren = 1'b1; radr = 10'd83;
    step();
    radr = 10'(DEPTH);
    step();
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL oor_read rdata=%0h expected 0", rdata);
    end
    ren = 1'b0; wen = 1'b1; wadr = 10'd1020; wdata = 128'hABCD;
    step();
    wen = 1'b0; ren = 1'b1; radr = 10'd83;
    step();
    checks++;
    if (rdata !== 128'd84) begin
      errors++; $display("FAIL oor_write_side rdata=%0d expected 84", rdata);
    end
    ren = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      wen = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(DEPTH - 3, 1023))
                                      : 10'($urandom_range(0, 31));
      wadr  = a;
      radr  = ($urandom_range(0, 3) == 0) ? a : 10'($urandom_range(0, 31));
      wdata = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (exp_known) begin
        checks++;
        if (rdata !== exp_rdata) begin
          errors++;
          $display("FAIL random_%0d rdata=%0h expected %0h", n, rdata, exp_rdata);
        end
      end
    end
    idle();
  endtask

`ifdef SRAM_PARITY_EN
  task automatic test_parity();
    dut.mem_q[97][0] = ~dut.mem_q[97][0];
    ren = 1'b1; radr = 10'd97;
    step();
    checks++;
    if (rerr !== 1'b1) begin
      errors++; $display("FAIL parity_flip rerr=%b expected 1", rerr);
    end
    radr = 10'd83;
    step();
    checks++;
    if (rerr !== 1'b0) begin
      errors++; $display("FAIL parity_clean rerr=%b expected 0", rerr);
    end
    ren = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mdl[i]       = '0;
      mdl_valid[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_read_first();
    test_async_reset();
    test_out_of_range();
`ifdef SRAM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram.md
SRAM -- requirements
Module: sram

Interface
REQ-001 Parameter DATA_WIDTH, default 128: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10: address width in bits.
REQ-003 Parameter DEPTH, default 1024: number of words; legal range 1..2^ADDR_WIDTH.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-005 clk  input  1  clock; all sampling on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 wen  input  1  write enable.
REQ-008 wadr  input  ADDR_WIDTH  write address.
REQ-009 wdata  input  DATA_WIDTH  write data.
REQ-010 ren  input  1  read enable.
REQ-011 radr  input  ADDR_WIDTH  read address.
REQ-012 rdata  output  DATA_WIDTH  registered read data.
REQ-013 rerr  output  1  parity error flag; present only with SRAM_PARITY_EN; otherwise absent.

Function
REQ-014 Storage SHALL be DEPTH words of DATA_WIDTH bits, with independent write and read ports sharing clk.
REQ-015 Write: on a rising edge with wen=1 and wadr<DEPTH, mem[wadr] SHALL become wdata; the new value SHALL be readable by a read issued on the next edge.
REQ-016 Read: on a rising edge with ren=1 and radr<DEPTH, rdata SHALL register mem[radr]; latency is exactly one clock, so data is valid after the edge that sampled ren.
REQ-017 With ren=0, rdata SHALL hold its last value indefinitely, including across writes to any address.
REQ-018 With ren=1, rdata SHALL update every edge, so reading a word that was written earlier returns the updated value.
REQ-019 Simultaneous read and write to the same address SHALL be read-first: rdata gets the old contents, and the new data is visible on the following read.
REQ-020 Writes with wadr>=DEPTH SHALL be ignored; reads with radr>=DEPTH SHALL load rdata with 0.
REQ-021 Uninitialised words are undefined; the bench SHALL NOT check them.
REQ-022 No other combinational path from inputs to outputs is permitted.

Reset
REQ-023 rst=1 SHALL clear rdata (and rerr) to 0 immediately, without waiting for a clock edge.
REQ-024 Memory contents SHALL NOT be cleared by reset.
REQ-025 While rst=1, writes and reads SHALL be ignored; normal operation resumes on the first rising edge after rst deasserts.
REQ-026 A write whose edge coincides with rst=1 SHALL NOT modify memory.

Configuration
REQ-027 Macro SRAM_PARITY_EN: when defined, each word stores an extra even-parity bit computed from wdata at write time.
REQ-028 With SRAM_PARITY_EN, every read SHALL recompute parity and register rerr=1 alongside rdata on mismatch, else 0; rerr holds when ren=0 and resets to 0.
REQ-029 Without SRAM_PARITY_EN, there SHALL be no parity storage and no rerr port; behaviour is otherwise identical.

Verification
REQ-030 Write 137 to address 97 (wen one cycle), then ren=1 with radr=97 -> rdata=137 one clock later.
REQ-031 Write 84 to address 83, then read address 83 -> rdata=84; then write 39 to address 4 with ren=0 -> rdata stays 84.
REQ-032 Read address 4 after the previous step -> rdata=39 one clock later; deassert ren -> rdata holds 39.
REQ-033 Same-edge write of 5 and read of address 10, which held 7 -> rdata=7; next read of address 10 -> rdata=5.
REQ-034 Assert rst mid-cycle while rdata=39 -> rdata=0 before the next edge; after release, read address 4 -> rdata=39 (contents retained).
REQ-035 With SRAM_PARITY_EN, force a stored bit flip at address 97 by hierarchical deposit, then read it -> rerr=1; read address 83 -> rerr=0.
